key_action_gen: RTL and testbench
=================================

Name: key_action_gen

Overview:
- Converts the raw 16-bit keyboard keycode into one-cycle Tetris action pulses: left, right, rotate, soft drop, hard drop.
- Horizontal moves use delayed auto-shift (DAS) with auto-repeat.
- Sits beside game_state and downstream of its gamestate/reset_game outputs. Pulses are emitted only while the game is in the Game state.
- Feeds the piece-movement/collision logic.

Parameters:
- DAS_CYCLES, 8000000, cycles from the initial horizontal pulse to the first auto-repeat pulse (160 ms at 50 MHz).
- ARR_CYCLES, 2500000, cycles between auto-repeat pulses after DAS expires.
- SOFT_CYCLES, 2500000, cycles between repeated soft-drop pulses while Down is held.
- CNT_W, 24, width of each internal counter. Must hold max(DAS_CYCLES, ARR_CYCLES, SOFT_CYCLES).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- keycode  in  16  two HID key slots: [7:0] and [15:8]; 8'h00 = no key
- gamestate  in  2  from game state block: 1 = Idle, 2 = Game, 3 = End
- reset_game  in  1  from game state block: board restart request
- move_left  out  1  one-cycle pulse
- move_right  out  1  one-cycle pulse
- rotate  out  1  one-cycle pulse
- soft_drop  out  1  one-cycle pulse
- hard_drop  out  1  one-cycle pulse

Behaviour:
- Key decode: a key is held if either byte equals its code.
  - Left = 8'h50, Right = 8'h4F, Down = 8'h51, Up (rotate) = 8'h52, Space (hard drop) = 8'h2C.
  - Enter (8'h28) is ignored here.
- held_q registers (one per key) hold the previous cycle's decode. They update every cycle regardless of gating.
  - edge = held & ~held_q.
- active = (gamestate == 2'd2) && !reset_game.
- All outputs are registered. A pulse at cycle t reflects inputs at cycle t-1. Latency from key appearance to first pulse = 1 cycle.
- Reset (synchronous, any time, including mid-repeat):
  - all outputs 0, all held_q 0, all counters 0, all FSMs IDLE.
- Horizontal FSM, one instance each for Left and Right. States IDLE, DELAY, REPEAT.
  - IDLE: on edge && active, pulse, clear counter, go to DELAY.
  - DELAY: counter increments each cycle. When counter == DAS_CYCLES-1, pulse, clear counter, go to REPEAT.
  - REPEAT: when counter == ARR_CYCLES-1, pulse, clear counter; otherwise increment.
  - Key released, or !active, in DELAY or REPEAT: go to IDLE, clear counter, no pulse that cycle.
- Left and Right both held: both FSMs are forced to IDLE and no horizontal pulses occur.
  - When one of them is released, the other is treated as freshly pressed: it pulses the next cycle and enters DELAY, even though it has no new edge.
- Rotate and hard_drop: pulse on edge && active only. No repeat while held.
- Soft drop: on edge && active, pulse and start a counter. While held and active, pulse every SOFT_CYCLES cycles. There is no DAS delay. Release or !active clears the counter.
- A key already held when active rises does not fire. It must be released and pressed again.
  - Example: Down held through End→Game produces no soft_drop.
- Any number of different pulses may assert in the same cycle; e.g. rotate and move_left together are legal.
- Counters saturate at their terminal compare and never wrap past it.

Test Plan (DAS_CYCLES=4, ARR_CYCLES=2, SOFT_CYCLES=3, gamestate=2 unless stated):
- keycode=16'h0050 on cycles 0–9, then 16'h0000 → move_left pulses at cycles 1, 5, 7, 9 only; move_right never asserts.
- keycode=16'h0052 held 6 cycles, then released, then pressed again at cycle 10 → rotate at cycles 1 and 11 only; likewise hard_drop for 16'h002C.
- keycode=16'h4F50 (Left+Right) for 5 cycles, then 16'h004F → no horizontal pulses during overlap; move_right at cycle 6 (first cycle after the drop to Right-only), then at 10, 12.
- Down held while gamestate=3, gamestate→2 at cycle 5, Down still held → no soft_drop. Release, re-press at cycle 12 → soft_drop at 13, 16, 19.
- Left held in REPEAT; gamestate→3 (or reset_game=1 for one cycle) → no further move_left; FSM in IDLE with counter 0 next cycle.
- Reset asserted for 1 cycle mid-DELAY with Left held, gamestate=2 → all outputs 0 during reset. Left then counts as a fresh edge: move_left 2 cycles after the reset cycle, with full DAS restart.

Source files
------------

// File: rtl/key_action_gen.sv
// Turns raw two-slot HID keycodes into one-cycle Tetris action pulses, with
// delayed auto-shift / auto-repeat on the horizontal moves and soft-drop repeat.
module key_action_gen #(
  parameter int DAS_CYCLES  = 8000000,
  parameter int ARR_CYCLES  = 2500000,
  parameter int SOFT_CYCLES = 2500000,
  parameter int CNT_W       = 24
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] keycode,
  input  logic [1:0]  gamestate,
  input  logic        reset_game,
  output logic        move_left,
  output logic        move_right,
  output logic        rotate,
  output logic        soft_drop,
  output logic        hard_drop
);

  typedef enum logic [1:0] {H_IDLE, H_DELAY, H_REPEAT} hstate_t;

  localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(ARR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);

  function automatic logic key_hit(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

  // Bit order everywhere: [0] left, [1] right, [2] rotate, [3] down, [4] space.
  logic [4:0] held, held_q, key_edge, pulse_nxt;
  logic       active, both;
  logic [1:0] oheld, oheld_q, hstart;

  hstate_t [1:0]            hstate, hstate_nxt;
  logic    [1:0][CNT_W-1:0] hcnt, hcnt_nxt;
  logic                     soft_run, soft_run_nxt;
  logic    [CNT_W-1:0]      soft_cnt, soft_cnt_nxt;

  always_comb begin
    held = {key_hit(keycode, 8'h2C), key_hit(keycode, 8'h51), key_hit(keycode, 8'h52),
            key_hit(keycode, 8'h4F), key_hit(keycode, 8'h50)};
  end

  assign key_edge = held & ~held_q;
  assign active   = (gamestate == 2'd2) && !reset_game;
  assign both     = held[0] & held[1];
  assign oheld    = {held[0], held[1]};
  assign oheld_q  = {held_q[0], held_q[1]};
  // Releasing one side of a Left+Right chord restarts the surviving side.
  assign hstart   = {2{active & ~both}} & held[1:0] & (key_edge[1:0] | (oheld_q & ~oheld));

  always_comb begin
    pulse_nxt    = '0;
    hstate_nxt   = hstate;
    hcnt_nxt     = hcnt;
    soft_run_nxt = soft_run;
    soft_cnt_nxt = soft_cnt;

    for (int i = 0; i < 2; i++) begin
      if (both || !held[i] || !active) begin
        hstate_nxt[i] = H_IDLE;
        hcnt_nxt[i]   = '0;
      end else begin
        case (hstate[i])
          H_IDLE: begin
            if (hstart[i]) begin
              pulse_nxt[i]  = 1'b1;
              hcnt_nxt[i]   = '0;
              hstate_nxt[i] = H_DELAY;
            end
          end
          H_DELAY: begin
            if (hcnt[i] == DAS_LAST) begin
              pulse_nxt[i]  = 1'b1;
              hcnt_nxt[i]   = '0;
              hstate_nxt[i] = H_REPEAT;
            end else begin
              hcnt_nxt[i] = hcnt[i] + CNT_W'(1);
            end
          end
          H_REPEAT: begin
            if (hcnt[i] == ARR_LAST) begin
              pulse_nxt[i] = 1'b1;
              hcnt_nxt[i]  = '0;
            end else begin
              hcnt_nxt[i] = hcnt[i] + CNT_W'(1);
            end
          end
          default: begin
            hstate_nxt[i] = H_IDLE;
            hcnt_nxt[i]   = '0;
          end
        endcase
      end
    end

    pulse_nxt[2] = key_edge[2] & active;
    pulse_nxt[4] = key_edge[4] & active;

    if (!held[3] || !active) begin
      soft_run_nxt = 1'b0;
      soft_cnt_nxt = '0;
    end else if (!soft_run) begin
      if (key_edge[3]) begin
        pulse_nxt[3] = 1'b1;
        soft_run_nxt = 1'b1;
        soft_cnt_nxt = '0;
      end
    end else if (soft_cnt == SOFT_LAST) begin
      pulse_nxt[3] = 1'b1;
      soft_cnt_nxt = '0;
    end else begin
      soft_cnt_nxt = soft_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_q   <= '0;
      hcnt     <= '0;
      soft_run <= 1'b0;
      soft_cnt <= '0;
      for (int i = 0; i < 2; i++) hstate[i] <= H_IDLE;
      {hard_drop, soft_drop, rotate, move_right, move_left} <= '0;
    end else begin
      held_q   <= held;
      hstate   <= hstate_nxt;
      hcnt     <= hcnt_nxt;
      soft_run <= soft_run_nxt;
      soft_cnt <= soft_cnt_nxt;
      {hard_drop, soft_drop, rotate, move_right, move_left} <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_key_action_gen.sv
// Bench for key_action_gen: hand-derived vector table for the directed cases,
// then random stimulus compared against a pulse-schedule reference model.
module tb_key_action_gen;

  localparam int DAS  = 4;
  localparam int ARR  = 2;
  localparam int SOFT = 3;

  logic        Clk = 1'b0;
  logic        Reset, reset_game;
  logic [15:0] keycode;
  logic [1:0]  gamestate;
  logic        move_left, move_right, rotate, soft_drop, hard_drop;

  always #5 Clk = ~Clk;

  key_action_gen #(
    .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .SOFT_CYCLES(SOFT), .CNT_W(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .gamestate(gamestate),
    .reset_game(reset_game), .move_left(move_left), .move_right(move_right),
    .rotate(rotate), .soft_drop(soft_drop), .hard_drop(hard_drop)
  );

  int errors = 0;
  int checks = 0;

  // exp bits: {hard_drop, soft_drop, rotate, move_right, move_left}
  typedef struct {
    logic [15:0] kc;
    logic [1:0]  gs;
    logic        rg;
    logic        rs;
    logic [4:0]  exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [15:0] kc, input logic [1:0] gs,
                              input logic rg, input logic rs, input logic [4:0] exp);
    vec_t v;
    v.kc = kc; v.gs = gs; v.rg = rg; v.rs = rs; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Reference model: each running key carries its age since the start pulse;
  // pulses are a closed-form schedule of that age.
  int   age_l = -1, age_r = -1, age_s = -1;
  logic q_l = 0, q_r = 0, q_d = 0, q_u = 0, q_s = 0;

  function automatic logic has(input logic [15:0] kc, input logic [7:0] c);
    return (kc[7:0] == c) || (kc[15:8] == c);
  endfunction

  function automatic logic hfire(input int age);
    return (age == DAS) || (age > DAS && ((age - DAS) % ARR) == 0);
  endfunction

  task automatic model_step(input logic [15:0] kc, input logic [1:0] gs,
                            input logic rg, input logic rs, output logic [4:0] e);
    logic l, r, d, u, s, act, both;
    l = has(kc, 8'h50); r = has(kc, 8'h4F); d = has(kc, 8'h51);
    u = has(kc, 8'h52); s = has(kc, 8'h2C);
    e = '0;
    if (rs) begin
      age_l = -1; age_r = -1; age_s = -1;
      {q_l, q_r, q_d, q_u, q_s} = '0;
    end else begin
      act  = (gs == 2'd2) && !rg;
      both = l && r;
      if (both || !l || !act) age_l = -1;
      else if (age_l < 0) begin
        if (!q_l || (q_r && !r)) begin age_l = 0; e[0] = 1'b1; end
      end else begin age_l++; e[0] = hfire(age_l); end
      if (both || !r || !act) age_r = -1;
      else if (age_r < 0) begin
        if (!q_r || (q_l && !l)) begin age_r = 0; e[1] = 1'b1; end
      end else begin age_r++; e[1] = hfire(age_r); end
      if (!d || !act) age_s = -1;
      else if (age_s < 0) begin
        if (!q_d) begin age_s = 0; e[3] = 1'b1; end
      end else begin age_s++; e[3] = ((age_s % SOFT) == 0); end
      e[2] = u && !q_u && act;
      e[4] = s && !q_s && act;
      q_l = l; q_r = r; q_d = d; q_u = u; q_s = s;
    end
  endtask

  task automatic cyc(input logic [15:0] kc, input logic [1:0] gs, input logic rg,
                     input logic rs, output logic [4:0] got, output logic [4:0] mexp);
    keycode = kc; gamestate = gs; reset_game = rg; Reset = rs;
    model_step(kc, gs, rg, rs, mexp);
    @(posedge Clk);
    #1;
    got = {hard_drop, soft_drop, rotate, move_right, move_left};
  endtask

  task automatic check(input string name, input int idx, input logic [4:0] got,
                       input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: pulses got %b expected %b", name, idx, got, exp);
    end
  endtask

  initial begin
    logic [4:0] got, mexp;
    logic [7:0] codes [8];
    logic [7:0] b0, b1;
    logic [1:0] gs;

    keycode = '0; gamestate = 2'd2; reset_game = 1'b0; Reset = 1'b1;

    // Reset, then Left held 10 cycles: pulses out at 1,5,7,9
    add(16'h0050, 2'd2, 0, 1, 5'b00000);
    for (int c = 0; c < 12; c++)
      add(c < 10 ? 16'h0050 : 16'h0000, 2'd2, 0, 0,
          (c == 0 || c == 4 || c == 6 || c == 8) ? 5'b00001 : 5'b00000);
    // Rotate and hard drop: edge only, re-press at cycle 10
    for (int c = 0; c < 12; c++)
      add((c < 6 || c >= 10) ? 16'h0052 : 16'h0000, 2'd2, 0, 0,
          (c == 0 || c == 10) ? 5'b00100 : 5'b00000);
    for (int c = 0; c < 12; c++)
      add((c < 6 || c >= 10) ? 16'h2C00 : 16'h0000, 2'd2, 0, 0,
          (c == 0 || c == 10) ? 5'b10000 : 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    // Left+Right chord, then Right only: pulses out at 6,10,12
    for (int c = 0; c < 13; c++)
      add(c < 5 ? 16'h4F50 : 16'h004F, 2'd2, 0, 0,
          (c == 5 || c == 9 || c == 11) ? 5'b00010 : 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    // Down held across End->Game: silent; re-press at 12 gives 13,16,19
    for (int c = 0; c < 20; c++)
      add((c < 9 || c >= 12) ? 16'h0051 : 16'h0000, c < 5 ? 2'd3 : 2'd2, 0, 0,
          (c == 12 || c == 15 || c == 18) ? 5'b01000 : 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    // Left in REPEAT, reset_game for one cycle, then End for one cycle
    for (int c = 0; c < 12; c++)
      add(16'h0050, 2'd2, c == 7, 0,
          (c == 0 || c == 4 || c == 6) ? 5'b00001 : 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    for (int c = 0; c < 10; c++)
      add(16'h5000, c == 7 ? 2'd3 : 2'd2, 0, 0,
          (c == 0 || c == 4 || c == 6) ? 5'b00001 : 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    // Reset mid-DELAY on the would-be DAS cycle; fresh start after it
    for (int c = 0; c < 12; c++)
      add(16'h0050, 2'd2, 0, c == 4,
          (c == 0 || c == 5 || c == 9 || c == 11) ? 5'b00001 : 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    // Rotate and Left in the same cycle; Enter ignored; pressed while Idle
    add(16'h5250, 2'd2, 0, 0, 5'b00101);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);
    add(16'h0028, 2'd2, 0, 0, 5'b00000);
    add(16'h2C52, 2'd1, 0, 0, 5'b00000);
    add(16'h0000, 2'd2, 0, 0, 5'b00000);

    foreach (vecs[k]) begin
      cyc(vecs[k].kc, vecs[k].gs, vecs[k].rg, vecs[k].rs, got, mexp);
      check("vec", k, got, vecs[k].exp);
    end

    // Random phase against the reference model
    codes = '{8'h00, 8'h50, 8'h4F, 8'h51, 8'h52, 8'h2C, 8'h28, 8'h00};
    b0 = 8'h00; b1 = 8'h00; gs = 2'd2;
    cyc(16'h0000, 2'd2, 0, 1, got, mexp);
    check("rand_reset", 0, got, mexp);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) b0 = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) b1 = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) b1 = 8'($urandom);
      if ($urandom_range(0, 79) == 0) gs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      cyc({b1, b0}, gs, $urandom_range(0, 59) == 0, $urandom_range(0, 499) == 0, got, mexp);
      check("rand", n, got, mexp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
